interrupt_sequencer: RTL
========================

Name: interrupt_sequencer

Overview:
Sequences external interrupt entry and return for the pipelined RV32 core. It latches edge-triggered requests and arbitrates among them by fixed priority. It waits for a safe point in the pipeline, then issues a one-cycle flush plus PC redirect to the handler vector and saves the resume PC. On uret it issues a second flush/redirect back to the saved PC. It sits beside the control decoder, which produces the csr-set/clear and uret pulses this block consumes, and feeds the PC-select and pipeline-flush logic.

Parameters:
N_IRQ, 3, number of interrupt sources; index 0 is highest priority.
VEC_BASE, 32'h0000_0100, handler address for source 0.
VEC_STRIDE, 32'h4, address step between consecutive source handlers.

Ports:
clk  in  1  core clock
rst  in  1  reset; synchronous, active-high
irq_in  in  N_IRQ  interrupt request levels, already synchronous to clk; rising edge = request
csr_set_mie  in  1  1-cycle pulse: retiring CSR instruction sets the global enable
csr_clr_mie  in  1  1-cycle pulse: retiring CSR instruction clears the global enable
uret  in  1  1-cycle pulse: uret retiring
pipe_hold  in  1  branch/jump redirect or stall in flight; interrupt entry not allowed
epc_candidate  in  32  PC of the oldest instruction not yet committed
epc_valid  in  1  epc_candidate is a real instruction, not a bubble
flush  out  1  kill all uncommitted instructions this cycle
redirect_valid  out  1  fetch PC must load redirect_pc this cycle
redirect_pc  out  32  target PC
irq_ack  out  N_IRQ  one-hot pulse naming the source being entered
mie  out  1  global interrupt enable
in_isr  out  1  handler currently executing
active_id  out  clog2(N_IRQ)  source being serviced; valid while in_isr
epc  out  32  saved resume PC

Behaviour:
- Reset (synchronous, rst=1 at posedge): state=IDLE; mie=0; pending=0; irq_q=0; epc=0; active_id=0. flush, redirect_valid, irq_ack, in_isr, redirect_pc are all 0.
- Edge detect: rise = irq_in & ~irq_q, where irq_q is irq_in registered each cycle.
  - pending <= (pending & ~clear_mask) | rise.
  - When a rise and a clear hit the same bit in the same cycle, the set wins.
  - A level already high when reset is released counts as one edge.
- Arbitration: sel = lowest index set in pending. This is combinational and used only in IDLE.
- States:
  - IDLE:
    - Takes an interrupt when mie && |pending && !pipe_hold && epc_valid.
    - On take: next=ENTER; latch active_id<=sel and epc<=epc_candidate.
    - Otherwise it stays in IDLE and pending is held.
    - uret in IDLE is ignored: no flush, no redirect.
  - ENTER (exactly 1 cycle, Moore outputs):
    - flush=1, redirect_valid=1, redirect_pc = VEC_BASE + active_id*VEC_STRIDE (32-bit, wraps mod 2^32).
    - irq_ack = one-hot(active_id).
    - Clears pending[active_id] and sets mie<=0.
    - next=IN_ISR.
  - IN_ISR:
    - in_isr=1; no nesting, so pending still accumulates but no entry is taken.
    - csr_set_mie/csr_clr_mie update mie normally.
    - uret -> next=RETURN.
  - RETURN (1 cycle):
    - flush=1, redirect_valid=1, redirect_pc=epc, in_isr=1.
    - Sets mie<=1; next=IDLE.
- mie update priority, highest first: rst > ENTER clear > RETURN set > csr_clr_mie > csr_set_mie.
  - When csr_set_mie and csr_clr_mie arrive together, clear wins.
- Latency:
  - An irq edge sampled at posedge E0 sets pending at E0.
  - The take decision is made at E1 if conditions hold.
  - flush/redirect are high in the cycle E1–E2.
  - Minimum edge-to-redirect is 2 edges.
  - uret asserted in the cycle before edge En gives RETURN outputs in the cycle En–En+1.
- A new interrupt may be taken in the first IDLE cycle after RETURN. Back-to-back service therefore needs at least 1 IDLE cycle.
- rst asserted in any state, including ENTER, IN_ISR or RETURN: everything returns to reset values on that edge. No redirect is issued and pending is lost.
- redirect_pc=0 whenever redirect_valid=0.

Test Plan:
- Reset, then csr_set_mie pulse, irq_in[1] 0->1 at E10 with pipe_hold=0, epc_valid=1, epc_candidate=32'h0000_0040 -> flush/redirect_valid/irq_ack=3'b010 high at cycle E11–E12 only; redirect_pc=32'h0000_0104; epc=32'h40; mie=0; in_isr=1 from E12.
- In IN_ISR, pulse uret -> next cycle flush=1, redirect_pc=32'h40, then state IDLE, mie=1, in_isr=0.
- mie=1, irq_in[2] and irq_in[0] rise together -> source 0 entered first (redirect 32'h100). After its uret, source 2 is entered after 1 IDLE cycle (redirect 32'h108).
- mie=1, pending[0] set while pipe_hold=1 for 5 cycles -> no flush during hold; entry 1 cycle after pipe_hold drops. Same check with epc_valid=0.
- mie=0 with irq edge -> pending held, no entry. csr_set_mie and csr_clr_mie in the same cycle -> mie stays 0. A later csr_set_mie alone -> entry 1 cycle later.
- rst pulsed during IN_ISR with pending[2]=1 -> all outputs and state at reset values; no entry after reset even with mie later set, until a new edge.

Source files
------------

// File: rtl/interrupt_sequencer.sv
// Interrupt entry/return sequencer for the pipelined RV32 core.
// Latches irq edges, arbitrates by fixed priority, and issues flush/redirect.
module interrupt_sequencer #(
    parameter int          N_IRQ      = 3,
    parameter logic [31:0] VEC_BASE   = 32'h0000_0100,
    parameter logic [31:0] VEC_STRIDE = 32'h4,
    localparam int         IDW        = (N_IRQ > 1) ? $clog2(N_IRQ) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_IRQ-1:0] irq_in,
    input  logic             csr_set_mie,
    input  logic             csr_clr_mie,
    input  logic             uret,
    input  logic             pipe_hold,
    input  logic [31:0]      epc_candidate,
    input  logic             epc_valid,
    output logic             flush,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    output logic [N_IRQ-1:0] irq_ack,
    output logic             mie,
    output logic             in_isr,
    output logic [IDW-1:0]   active_id,
    output logic [31:0]      epc
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ENTER,
        S_IN_ISR,
        S_RETURN
    } state_t;

    state_t           state;
    logic [N_IRQ-1:0] irq_q;
    logic [N_IRQ-1:0] pending;
    logic [N_IRQ-1:0] rise;
    logic [N_IRQ-1:0] clr_mask;
    logic [N_IRQ-1:0] sel_oh;
    logic [N_IRQ-1:0] act_oh;
    logic [IDW-1:0]   sel;
    logic [31:0]      vec_pc;
    logic             take;

    // Fixed-priority pick: lowest pending index wins.
    always_comb begin
        sel = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (pending[i]) sel = IDW'(i);
        end
    end

    // One-hot forms of the selected and active source, plus entry terms.
    always_comb begin
        sel_oh         = '0;
        sel_oh[sel]    = 1'b1;
        act_oh         = '0;
        act_oh[active_id] = 1'b1;
        rise     = irq_in & ~irq_q;
        clr_mask = (state == S_ENTER) ? act_oh : '0;
        vec_pc   = VEC_BASE + 32'(sel) * VEC_STRIDE;
        take     = mie & (|pending) & ~pipe_hold & epc_valid;
    end

    // Sequencer FSM with registered flush/redirect/ack outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            irq_q          <= '0;
            pending        <= '0;
            mie            <= 1'b0;
            in_isr         <= 1'b0;
            active_id      <= '0;
            epc            <= '0;
            flush          <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            irq_ack        <= '0;
        end else begin
            irq_q          <= irq_in;
            pending        <= (pending & ~clr_mask) | rise;
            flush          <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            irq_ack        <= '0;
            unique case (state)
                S_IDLE: begin
                    if (csr_clr_mie)      mie <= 1'b0;
                    else if (csr_set_mie) mie <= 1'b1;
                    if (take) begin
                        state          <= S_ENTER;
                        active_id      <= sel;
                        epc            <= epc_candidate;
                        flush          <= 1'b1;
                        redirect_valid <= 1'b1;
                        redirect_pc    <= vec_pc;
                        irq_ack        <= sel_oh;
                    end
                end
                S_ENTER: begin
                    mie    <= 1'b0;
                    in_isr <= 1'b1;
                    state  <= S_IN_ISR;
                end
                S_IN_ISR: begin
                    if (csr_clr_mie)      mie <= 1'b0;
                    else if (csr_set_mie) mie <= 1'b1;
                    if (uret) begin
                        state          <= S_RETURN;
                        flush          <= 1'b1;
                        redirect_valid <= 1'b1;
                        redirect_pc    <= epc;
                    end
                end
                S_RETURN: begin
                    mie    <= 1'b1;
                    in_isr <= 1'b0;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
